// File: rtl/pipe_adder_pkg.sv
// Shared types and defaults for the pipelined ripple adder.
package pipe_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefSegW  = 8;

  // Number of pipeline stages; a zero segment width is caught by the top's elaboration check.
  function automatic int unsigned calc_nstg(input int unsigned width, input int unsigned seg_w);
    return (seg_w == 0) ? 1 : width / seg_w;
  endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG_W-bit ripple-carry segment used by each pipeline stage.
module adder_seg #(
  parameter int unsigned SEG_W = 8
) (
  input  logic [SEG_W-1:0] seg_a,
  input  logic [SEG_W-1:0] seg_b,
  input  logic             seg_cin,
  output logic [SEG_W-1:0] seg_s,
  output logic             seg_cout
);

  logic carry;

  // Bit-serial full-adder chain across the segment.
  always_comb begin
    carry = seg_cin;
    seg_s = '0;
    for (int unsigned i = 0; i < SEG_W; i++) begin
      seg_s[i] = seg_a[i] ^ seg_b[i] ^ carry;
      carry    = (seg_a[i] & seg_b[i]) | (carry & (seg_a[i] ^ seg_b[i]));
    end
    seg_cout = carry;
  end

endmodule

// File: rtl/pipe_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: the carry chain is cut every SEG_W bits into register
// stages, with skewed operands and deskewed results so the whole word emerges together.
// Optional signed-overflow output is built only when PIPE_RIPPLE_ADDER_OVF_EN is defined.
module pipe_ripple_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SEG_W = DefSegW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned NSTG = calc_nstg(WIDTH, SEG_W);

  if (SEG_W < 1) begin : g_chk_seg
    $fatal(1, "pipe_ripple_adder: SEG_W must be at least 1");
  end else if ((WIDTH % SEG_W) != 0) begin : g_chk_div
    $fatal(1, "pipe_ripple_adder: WIDTH must be a multiple of SEG_W");
  end

  // Values presented to stage k: operands (b already inverted for SUB), carry in, and the
  // result bits already resolved by earlier stages.
  logic [WIDTH-1:0] stg_a [NSTG];
  logic [WIDTH-1:0] stg_b [NSTG];
  logic [WIDTH-1:0] stg_s [NSTG];
  logic [NSTG-1:0]  stg_c;
  logic [SEG_W-1:0] seg_s [NSTG];
  logic [NSTG-1:0]  seg_co;

  logic [WIDTH-1:0] opa_q [NSTG];
  logic [WIDTH-1:0] opa_d [NSTG];
  logic [WIDTH-1:0] opb_q [NSTG];
  logic [WIDTH-1:0] opb_d [NSTG];
  logic [WIDTH-1:0] sum_q [NSTG];
  logic [WIDTH-1:0] sum_d [NSTG];
  logic [NSTG-1:0]  cry_q, cry_d;
  logic [NSTG-1:0]  vld_q, vld_d;

  logic advance;
  logic is_sub;

  // The whole pipe moves as one; it only freezes when a finished result is not taken.
  assign advance  = !vld_q[NSTG-1] || out_ready;
  assign in_ready = advance;
  assign is_sub   = (op == OP_SUB);

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    if (k == 0) begin : g_first
      assign stg_a[k] = a;
      assign stg_b[k] = is_sub ? ~b : b;
      assign stg_s[k] = '0;
      assign stg_c[k] = is_sub | carry_in;
    end else begin : g_rest
      assign stg_a[k] = opa_q[k-1];
      assign stg_b[k] = opb_q[k-1];
      assign stg_s[k] = sum_q[k-1];
      assign stg_c[k] = cry_q[k-1];
    end

    adder_seg #(
      .SEG_W(SEG_W)
    ) u_seg (
      .seg_a   (stg_a[k][k*SEG_W +: SEG_W]),
      .seg_b   (stg_b[k][k*SEG_W +: SEG_W]),
      .seg_cin (stg_c[k]),
      .seg_s   (seg_s[k]),
      .seg_cout(seg_co[k])
    );
  end

  // Next-state: shift every stage forward on advance, otherwise hold.
  always_comb begin
    vld_d = vld_q;
    cry_d = cry_q;
    for (int unsigned k = 0; k < NSTG; k++) begin
      opa_d[k] = opa_q[k];
      opb_d[k] = opb_q[k];
      sum_d[k] = sum_q[k];
    end
    if (advance) begin
      vld_d[0] = in_valid;
      for (int unsigned k = 1; k < NSTG; k++) begin
        vld_d[k] = vld_q[k-1];
      end
      for (int unsigned k = 0; k < NSTG; k++) begin
        opa_d[k]                   = stg_a[k];
        opb_d[k]                   = stg_b[k];
        sum_d[k]                   = stg_s[k];
        sum_d[k][k*SEG_W +: SEG_W] = seg_s[k];
        cry_d[k]                   = seg_co[k];
      end
    end
  end

  // Stage registers; reset discards any in-flight beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cry_q <= '0;
      for (int unsigned k = 0; k < NSTG; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cry_q <= cry_d;
      for (int unsigned k = 0; k < NSTG; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign out_valid = vld_q[NSTG-1];
  assign s         = sum_q[NSTG-1];
  assign carry_out = cry_q[NSTG-1];

`ifdef PIPE_RIPPLE_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  logic msb_cin;

  // Carry into the MSB recovered from the MSB sum bit of the last segment.
  assign msb_cin = stg_a[NSTG-1][WIDTH-1] ^ stg_b[NSTG-1][WIDTH-1] ^ seg_s[NSTG-1][SEG_W-1];

  // Overflow is captured alongside the last stage and holds with it.
  always_comb begin
    ovf_d = ovf_q;
    if (advance) begin
      ovf_d = msb_cin ^ seg_co[NSTG-1];
    end
  end

  // Overflow register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ripple_adder.sv
// Scoreboard bench for pipe_ripple_adder (default 32-bit, 8-bit segments).
module tb_pipe_ripple_adder;

  localparam int W    = 32;
  localparam int NSTG = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         carry_out;
  logic         overflow;

  pipe_ripple_adder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk   = 0;
  int   n_err   = 0;
  int   cyc     = 0;
  bit   lat_chk = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_in,
                                 input logic tc, input logic top);
    exp_t         e;
    logic [W-1:0] bb;
    logic         c0;
    logic [W:0]   r;
    bb   = top ? ~tb_in : tb_in;
    c0   = top ? 1'b1 : tc;
    r    = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, c0};
    e.s  = r[W-1:0];
    e.co = r[W];
`ifdef PIPE_RIPPLE_ADDER_OVF_EN
    e.ov = (ta[W-1] == bb[W-1]) && (r[W-1] != ta[W-1]);
`else
    e.ov = 1'b0;
`endif
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: retire results against the scoreboard and record accepted beats.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && !out_ready) begin
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        if (sb.size() > 0) begin
          check("hold_s", {32'd0, s}, {32'd0, sb[0].s});
          check("hold_cout", {63'd0, carry_out}, {63'd0, sb[0].co});
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", {63'd0, out_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("s", {32'd0, s}, {32'd0, e.s});
          check("carry_out", {63'd0, carry_out}, {63'd0, e.co});
          check("overflow", {63'd0, overflow}, {63'd0, e.ov});
          if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'(NSTG));
        end
      end
      if (in_valid && in_ready) begin
        e     = model(a, b, carry_in, op);
        e.cyc = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_in, input logic tc,
                      input logic top);
    int   n   = 0;
    logic rdy = 1'b0;
    a        = ta;
    b        = tb_in;
    carry_in = tc;
    op       = top;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      step();
      n++;
    end while (!rdy && n < 40);
    if (!rdy) check("accept_timeout", {63'd0, rdy}, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    repeat (3) step();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    carry_in  = 1'b0;
    op        = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_s", {32'd0, s}, 64'd0);
    check("rst_cout", {63'd0, carry_out}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    step();

    // Basic add, full carry ripple, back-to-back stream.
    lat_chk = 1'b1;
    send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    drain();
    send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) send(W'(i), W'(i), 1'b0, 1'b0);
    drain();

    // Subtract, including carry_in being ignored.
    send(32'h0, 32'h1, 1'b0, 1'b1);
    send(32'd10, 32'd3, 1'b1, 1'b1);
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    drain();

    // Signed overflow corner.
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    drain();

    // Backpressure mid-stream.
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(W'(32'h100 + i), W'(i * 7), 1'(i % 2), 1'(i / 4));
      end
      begin
        repeat (5) step();
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight.
    lat_chk = 1'b1;
    send(32'h11, 32'h22, 1'b0, 1'b0);
    send(32'h33, 32'h44, 1'b1, 1'b0);
    send(32'h55, 32'h66, 1'b0, 1'b1);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    repeat (6) step();
    send(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0);
    drain();
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
